mem_port_arbiter: RTL and testbench

- Shares one unified, word-addressed, single-port memory between the CPU instruction-fetch port and the CPU data port.
- Sits between the cpu core's iaddr/idata and daddr/drdata/dwdata/dwe interfaces and the memory macro.
- Serialises accesses with one outstanding transaction at a time.
- Arbitrates simultaneous requests and returns read data to the correct requester after a fixed memory latency.

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, word-addressed memory between the
// CPU instruction-fetch port and the CPU data port. One transaction is in
// flight at a time; read data is steered back to the port that issued it
// after RD_LATENCY cycles.
module mem_port_arbiter #(
  parameter int unsigned RD_LATENCY = 1,   // 1..15 cycles, grant edge to m_rdata valid
  parameter bit          DATA_PRIO  = 1'b0 // 0: round-robin, 1: data port always wins
) (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch port (read only)
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  // data port
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_we,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  // memory macro side
  output logic        m_req,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_we,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter preload on a read grant; WAIT counts it down to 1.
  localparam logic [3:0] LAT_M1 = 4'(RD_LATENCY - 32'd1);
  localparam bit         LAT_ONE = (RD_LATENCY == 32'd1);

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        owner_r, owner_s;   // 1: read in flight belongs to the data port
  logic        fav_d_r, fav_d_s;   // 1: data port wins the next tie (round-robin)
  logic        grant_i_s, grant_d_s;
  logic        resp_s;

  // Combinational arbitration: grants only in IDLE and never while reset is high.
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (!reset && (state_r == IDLE)) begin
      if (d_req && (!i_req || DATA_PRIO || fav_d_r)) begin
        grant_d_s = 1'b1;
      end else if (i_req) begin
        grant_i_s = 1'b1;
      end else begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
      end
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  assign i_gnt = grant_i_s;
  assign d_gnt = grant_d_s;

  // Drive the memory strobe and access fields from the winning port; idle value is zero.
  always_comb begin
    m_req   = grant_i_s | grant_d_s;
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    m_we    = 4'd0;
    if (grant_d_s) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_we    = d_we;
    end else if (grant_i_s) begin
      m_addr  = i_addr;   // fetches are always reads with zero write data
    end else begin
      m_addr  = 32'd0;
    end
  end

  // Next-state logic: record read ownership, count out the latency, then respond once.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    owner_s = owner_r;
    fav_d_s = fav_d_r;
    case (state_r)
      IDLE: begin
        if (grant_d_s) begin
          fav_d_s = 1'b0;
          if (d_we == 4'd0) begin
            owner_s = 1'b1;
            cnt_s   = LAT_M1;
            state_s = LAT_ONE ? RESP : WAIT;
          end else begin
            state_s = IDLE;   // writes complete at the grant edge
          end
        end else if (grant_i_s) begin
          fav_d_s = 1'b1;
          owner_s = 1'b0;
          cnt_s   = LAT_M1;
          state_s = LAT_ONE ? RESP : WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        cnt_s = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State register; reset abandons any in-flight read and re-favours the fetch port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      owner_r <= 1'b0;
      fav_d_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      owner_r <= owner_s;
      fav_d_r <= fav_d_s;
    end
  end

  // Response steering: only the owner sees rvalid, and rdata is zero whenever rvalid is low.
  always_comb begin
    resp_s   = !reset && (state_r == RESP);
    i_rvalid = resp_s && !owner_r;
    d_rvalid = resp_s && owner_r;
    i_rdata  = 32'd0;
    d_rdata  = 32'd0;
    if (i_rvalid) begin
      i_rdata = m_rdata;
    end else if (d_rvalid) begin
      d_rdata = m_rdata;
    end else begin
      i_rdata = 32'd0;
      d_rdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. Two instances run side by side:
// cfg0 = RD_LATENCY 1 / round-robin, cfg1 = RD_LATENCY 3 / data priority.
// A cycle-level reference model predicts grants and pushes expected read
// responses into a scoreboard; a separate monitor pops them when rvalid shows.
module tb_mem_port_arbiter;

  localparam int unsigned LAT0  = 1;
  localparam bit          PRIO0 = 1'b0;
  localparam int unsigned LAT1  = 3;
  localparam bit          PRIO1 = 1'b1;

  logic        clk;
  logic        reset;
  logic        i_req    [2];
  logic [31:0] i_addr   [2];
  logic        i_gnt    [2];
  logic        i_rvalid [2];
  logic [31:0] i_rdata  [2];
  logic        d_req    [2];
  logic [31:0] d_addr   [2];
  logic [31:0] d_wdata  [2];
  logic [3:0]  d_we     [2];
  logic        d_gnt    [2];
  logic        d_rvalid [2];
  logic [31:0] d_rdata  [2];
  logic        m_req    [2];
  logic [31:0] m_addr   [2];
  logic [31:0] m_wdata  [2];
  logic [3:0]  m_we     [2];
  logic [31:0] m_rdata  [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit stop     = 1'b0;

  typedef struct {
    int          k;
    bit          dport;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  mem_port_arbiter #(.RD_LATENCY(LAT0), .DATA_PRIO(PRIO0)) dut0 (
    .clk(clk), .reset(reset),
    .i_req(i_req[0]), .i_addr(i_addr[0]), .i_gnt(i_gnt[0]),
    .i_rvalid(i_rvalid[0]), .i_rdata(i_rdata[0]),
    .d_req(d_req[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_we(d_we[0]),
    .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .m_req(m_req[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]), .m_we(m_we[0]),
    .m_rdata(m_rdata[0])
  );

  mem_port_arbiter #(.RD_LATENCY(LAT1), .DATA_PRIO(PRIO1)) dut1 (
    .clk(clk), .reset(reset),
    .i_req(i_req[1]), .i_addr(i_addr[1]), .i_gnt(i_gnt[1]),
    .i_rvalid(i_rvalid[1]), .i_rdata(i_rdata[1]),
    .d_req(d_req[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_we(d_we[1]),
    .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .m_req(m_req[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]), .m_we(m_we[1]),
    .m_rdata(m_rdata[1])
  );

  function automatic int lat(input int k);
    return (k == 0) ? int'(LAT0) : int'(LAT1);
  endfunction

  function automatic bit prio(input int k);
    return (k == 0) ? PRIO0 : PRIO1;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d cyc=%0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory macro stand-in (driven by DUT m_* outputs) ----------------
  logic [31:0] mem_m [2][16];
  logic [31:0] pipe  [2][4];

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) mem_m[k][i] = 32'hC0DE_0000 + 32'(i);
      for (int j = 0; j < 4; j++) pipe[k][j] = 32'd0;
    end
  end

  assign m_rdata[0] = pipe[0][0];
  assign m_rdata[1] = pipe[1][0];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) pipe[k][j] <= pipe[k][j+1];
      if (m_req[k] && (m_we[k] == 4'd0)) pipe[k][lat(k)-1] <= mem_m[k][m_addr[k][3:0]];
      else                               pipe[k][lat(k)-1] <= $urandom;
      if (m_req[k]) begin
        for (int b = 0; b < 4; b++)
          if (m_we[k][b]) mem_m[k][m_addr[k][3:0]][8*b +: 8] <= m_wdata[k][8*b +: 8];
      end
    end
  end

  // ---------------- reference model: predicts grants, pushes expected reads ----------------
  logic [31:0] mm [2][16];
  int          free_at [2];
  bit          fav_d   [2];
  bit          rst_prev = 1'b1;

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) mm[k][i] = 32'hC0DE_0000 + 32'(i);
      free_at[k] = 0;
      fav_d[k]   = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit gi, gd, idle;
      logic [31:0] ea, ew;
      logic [3:0]  ewe;
      if (reset) begin
        chk("rst i_gnt",    k, i_gnt[k],    0);
        chk("rst d_gnt",    k, d_gnt[k],    0);
        chk("rst m_req",    k, m_req[k],    0);
        chk("rst m_addr",   k, m_addr[k],   0);
        chk("rst m_wdata",  k, m_wdata[k],  0);
        chk("rst m_we",     k, m_we[k],     0);
        chk("rst i_rvalid", k, i_rvalid[k], 0);
        chk("rst d_rvalid", k, d_rvalid[k], 0);
        free_at[k] = cyc + 1;
        fav_d[k]   = 1'b0;
      end else begin
        idle = (cyc >= free_at[k]);
        gd   = idle && d_req[k] && (!i_req[k] || prio(k) || fav_d[k]);
        gi   = idle && i_req[k] && !gd;
        chk("i_gnt", k, i_gnt[k], gi);
        chk("d_gnt", k, d_gnt[k], gd);
        chk("m_req", k, m_req[k], gi | gd);
        if (gi || gd) begin
          ea  = gd ? d_addr[k]  : i_addr[k];
          ew  = gd ? d_wdata[k] : 32'd0;
          ewe = gd ? d_we[k]    : 4'd0;
          chk("m_addr",  k, m_addr[k],  ea);
          chk("m_wdata", k, m_wdata[k], ew);
          chk("m_we",    k, m_we[k],    ewe);
        end else if (rst_prev) begin
          chk("post-rst m_addr",  k, m_addr[k],  0);
          chk("post-rst m_wdata", k, m_wdata[k], 0);
          chk("post-rst m_we",    k, m_we[k],    0);
        end
        if (gi) begin
          fav_d[k] = 1'b1;
          sb.push_back('{k: k, dport: 1'b0, data: mm[k][i_addr[k][3:0]], due: cyc + lat(k)});
          free_at[k] = cyc + lat(k) + 1;
        end else if (gd) begin
          fav_d[k] = 1'b0;
          if (d_we[k] == 4'd0) begin
            sb.push_back('{k: k, dport: 1'b1, data: mm[k][d_addr[k][3:0]], due: cyc + lat(k)});
            free_at[k] = cyc + lat(k) + 1;
          end else begin
            for (int b = 0; b < 4; b++)
              if (d_we[k][b]) mm[k][d_addr[k][3:0]][8*b +: 8] = d_wdata[k][8*b +: 8];
          end
        end
      end
    end
    if (reset) sb.delete();
    rst_prev = reset;
  end

  // ---------------- monitor: pops expected reads when the DUT shows rvalid ----------------
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int idx;
      bit rv;
      idx = -1;
      for (int j = 0; j < sb.size(); j++) begin
        if (idx < 0 && sb[j].k == k) idx = j;
      end
      rv = i_rvalid[k] | d_rvalid[k];
      chk("rvalid exclusive", k, i_rvalid[k] & d_rvalid[k], 0);
      if (!i_rvalid[k]) chk("i_rdata idle zero", k, i_rdata[k], 0);
      if (!d_rvalid[k]) chk("d_rdata idle zero", k, d_rdata[k], 0);
      if (rv) begin
        if (idx < 0) begin
          chk("unexpected rvalid", k, rv, 0);
        end else begin
          chk("rvalid port", k, d_rvalid[k], sb[idx].dport);
          chk("rvalid cycle", k, cyc, sb[idx].due);
          chk("rdata", k, sb[idx].dport ? d_rdata[k] : i_rdata[k], sb[idx].data);
          sb.delete(idx);
        end
      end else if (!reset && idx >= 0 && sb[idx].due <= cyc) begin
        chk("missed rvalid", k, rv, 1);
        sb.delete(idx);
      end
    end
  end

  // ---------------- stimulus: one process per port per instance ----------------
  task automatic drive_port(input int k, input bit dp);
    bit g, rp, cur;
    forever begin
      @(negedge clk);
      g  = dp ? d_gnt[k] : i_gnt[k];
      rp = reset;
      @(posedge clk);
      #2;
      cur = dp ? d_req[k] : i_req[k];
      if (reset || rp || stop) begin
        cur = 1'b0;
      end else if (cur && !g) begin
        if ($urandom_range(0, 15) == 0) cur = 1'b0;   // legal withdrawal before grant
      end else begin
        cur = ($urandom_range(0, 3) != 0);
        if (dp) begin
          d_addr[k]  = $urandom;
          d_wdata[k] = $urandom;
          d_we[k]    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
        end else begin
          i_addr[k]  = $urandom;
        end
      end
      if (dp) d_req[k] = cur;
      else    i_req[k] = cur;
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0; i_addr[k] = 32'd0;
      d_req[k] = 1'b0; d_addr[k] = 32'd0; d_wdata[k] = 32'd0; d_we[k] = 4'd0;
    end
    fork
      drive_port(0, 1'b0);
      drive_port(0, 1'b1);
      drive_port(1, 1'b0);
      drive_port(1, 1'b1);
    join_none
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int s = 0; s < 5; s++) begin
      repeat ($urandom_range(150, 350)) @(posedge clk);
      #1 reset = 1'b1;
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1 reset = 1'b0;
    end
    repeat (300) @(posedge clk);
    #1 stop = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("scoreboard drained", 0, sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
